// File: rtl/sat_counter_pkg.sv
// Shared definitions for the saturating/wrapping threshold counter.
// Holds the per-channel mode encoding and the parameter legality check.
package sat_counter_pkg;

    typedef enum logic {
        MODE_SATURATE = 1'b0,
        MODE_WRAP     = 1'b1
    } count_mode_e;

    // LIMIT must be reachable in WIDTH bits and non-zero; CHANNELS must be at least one.
    function automatic bit params_legal(input int channels, input int width, input int limit);
        params_legal = (channels >= 1) && (width >= 2) && (limit >= 1) &&
                       (limit <= ((1 << width) - 1));
    endfunction

endpackage

// File: rtl/sat_counter_channel.sv
// One counter channel: clear/advance/saturate-or-wrap, compare flags and a
// registered terminal-event pulse.
module sat_counter_channel
    import sat_counter_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int LIMIT = 7
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             advance,
    input  logic             sync_clear,
    input  logic             mode,
    input  logic [WIDTH-1:0] threshold,
    output logic [WIDTH-1:0] count,
    output logic             above,
    output logic             at_limit,
    output logic             done_pulse
);

    localparam logic [WIDTH-1:0] LIMIT_V = LIMIT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_V   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;
    logic             done_r;
    logic             done_next_s;

    // Next count and terminal-event detection; clear wins over any advance.
    always_comb begin
        count_next_s = count_r;
        done_next_s  = 1'b0;
        if (sync_clear) begin
            count_next_s = {WIDTH{1'b0}};
        end else if (advance) begin
            if (count_r < LIMIT_V) begin
                count_next_s = count_r + ONE_V;
                done_next_s  = (count_r == (LIMIT_V - ONE_V));
            end else if (mode == MODE_WRAP) begin
                count_next_s = {WIDTH{1'b0}};
                done_next_s  = 1'b1;
            end else begin
                count_next_s = count_r;
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Count and pulse registers with asynchronous clear.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            count_r <= {WIDTH{1'b0}};
            done_r  <= 1'b0;
        end else begin
            count_r <= count_next_s;
            done_r  <= done_next_s;
        end
    end

    assign count      = count_r;
    assign done_pulse = done_r;
    assign above      = (count_r >= threshold);
    assign at_limit   = (count_r == LIMIT_V);

endmodule

// File: rtl/sat_threshold_counter.sv
// Multi-channel saturating/wrapping counter with a shared advance strobe
// and a shared compare threshold.
module sat_threshold_counter
    import sat_counter_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 3,
    parameter int LIMIT    = 7
) (
    input  logic                      clock,
    input  logic                      clear_n,
    input  logic                      tick,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       sync_clear,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [WIDTH-1:0]          threshold,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       above,
    output logic [CHANNELS-1:0]       at_limit,
    output logic [CHANNELS-1:0]       done_pulse
);

    if (!params_legal(CHANNELS, WIDTH, LIMIT)) begin : g_bad_params
        $error("sat_threshold_counter: illegal CHANNELS/WIDTH/LIMIT combination");
    end

    logic [CHANNELS-1:0] advance_s;

    assign advance_s = {CHANNELS{tick}} & enable & ~sync_clear;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        sat_counter_channel #(
            .WIDTH (WIDTH),
            .LIMIT (LIMIT)
        ) u_channel (
            .clock      (clock),
            .clear_n    (clear_n),
            .advance    (advance_s[i]),
            .sync_clear (sync_clear[i]),
            .mode       (mode[i]),
            .threshold  (threshold),
            .count      (count[i*WIDTH +: WIDTH]),
            .above      (above[i]),
            .at_limit   (at_limit[i]),
            .done_pulse (done_pulse[i])
        );
    end

endmodule

// File: tb/tb_sat_threshold_counter.sv
// Directed bench for sat_threshold_counter (CHANNELS=2, WIDTH=3, LIMIT=7).
module tb_sat_threshold_counter;

    logic       clock;
    logic       clear_n;
    logic       tick;
    logic [1:0] enable;
    logic [1:0] sync_clear;
    logic [1:0] mode;
    logic [2:0] threshold;
    logic [5:0] count;
    logic [1:0] above;
    logic [1:0] at_limit;
    logic [1:0] done_pulse;

    int n_checks;
    int n_fails;

    sat_threshold_counter #(
        .CHANNELS (2),
        .WIDTH    (3),
        .LIMIT    (7)
    ) dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .tick       (tick),
        .enable     (enable),
        .sync_clear (sync_clear),
        .mode       (mode),
        .threshold  (threshold),
        .count      (count),
        .above      (above),
        .at_limit   (at_limit),
        .done_pulse (done_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [2:0] exp_c;
        n_checks   = 0;
        n_fails    = 0;
        clear_n    = 1'b0;
        tick       = 1'b0;
        enable     = 2'b00;
        sync_clear = 2'b00;
        mode       = 2'b00;
        threshold  = 3'd4;

        // Reset state
        #12;
        check_value("rst_count", 32'(count), 32'd0);
        check_value("rst_done", 32'(done_pulse), 32'd0);
        check_value("rst_at_limit", 32'(at_limit), 32'd0);
        check_value("rst_above_t4", 32'(above), 32'd0);
        threshold = 3'd0;
        #1;
        check_value("rst_above_t0", 32'(above), 32'd3);
        threshold = 3'd4;
        step();
        clear_n = 1'b1;

        // Saturating count on channel 0 only
        tick   = 1'b1;
        enable = 2'b01;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp_c = (i < 7) ? 3'(i) : 3'd7;
            check_value("sat_count", 32'(count), 32'({3'd0, exp_c}));
            check_value("sat_above", 32'(above), 32'({1'b0, exp_c >= 3'd4}));
            check_value("sat_at_limit", 32'(at_limit), 32'({1'b0, exp_c == 3'd7}));
            check_value("sat_done", 32'(done_pulse), 32'({1'b0, i == 7}));
        end

        // Clear at LIMIT with advance active: no pulse
        sync_clear = 2'b01;
        step();
        check_value("clr7_count", 32'(count), 32'd0);
        check_value("clr7_done", 32'(done_pulse), 32'd0);
        sync_clear = 2'b00;

        // Wrap mode on channel 0
        mode = 2'b01;
        for (int i = 1; i <= 9; i++) begin
            step();
            exp_c = (i <= 7) ? 3'(i) : 3'(i - 8);
            check_value("wrap_count", 32'(count), 32'({3'd0, exp_c}));
            check_value("wrap_done", 32'(done_pulse), 32'({1'b0, (i == 7) || (i == 8)}));
        end

        // Shared tick gating, both channels
        mode       = 2'b00;
        sync_clear = 2'b11;
        step();
        check_value("clr_both", 32'(count), 32'd0);
        sync_clear = 2'b00;
        enable     = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick = (i % 2 == 0) ? 1'b1 : 1'b0;
            step();
            exp_c = 3'((i / 2) + 1);
            check_value("tick_gate", 32'(count), 32'({exp_c, exp_c}));
        end

        // Sync clear mid-count overrides advance
        tick   = 1'b1;
        enable = 2'b01;
        for (int i = 0; i < 3; i++) step();
        check_value("ch0_at5", 32'(count), 32'({3'd2, 3'd5}));
        sync_clear = 2'b01;
        step();
        check_value("clr5_count", 32'(count), 32'({3'd2, 3'd0}));
        check_value("clr5_done", 32'(done_pulse), 32'd0);
        sync_clear = 2'b00;
        for (int i = 0; i < 7; i++) step();
        check_value("reach7_count", 32'(count), 32'({3'd2, 3'd7}));
        check_value("reach7_done", 32'(done_pulse), 32'd1);
        step();
        check_value("hold7_count", 32'(count), 32'({3'd2, 3'd7}));
        check_value("hold7_done", 32'(done_pulse), 32'd0);

        // Mode switch while saturated wraps on the next advance
        mode = 2'b01;
        step();
        check_value("modesw_count", 32'(count), 32'({3'd2, 3'd0}));
        check_value("modesw_done", 32'(done_pulse), 32'd1);
        mode = 2'b00;

        // Asynchronous reset between edges at count 6
        for (int i = 0; i < 6; i++) step();
        check_value("pre_rst6", 32'(count), 32'({3'd2, 3'd6}));
        #3;
        clear_n = 1'b0;
        #1;
        check_value("async_count", 32'(count), 32'd0);
        check_value("async_done", 32'(done_pulse), 32'd0);
        check_value("async_at_limit", 32'(at_limit), 32'd0);
        #1;
        clear_n = 1'b1;
        step();
        check_value("resume_count", 32'(count), 32'd1);

        // Threshold sweep at count 7, then at count 3
        for (int i = 0; i < 6; i++) step();
        tick = 1'b0;
        check_value("at7_count", 32'(count), 32'd7);
        threshold = 3'd0;
        #1;
        check_value("thr0_at7", 32'(above), 32'd3);
        threshold = 3'd4;
        #1;
        check_value("thr4_at7", 32'(above), 32'd1);
        threshold = 3'd7;
        #1;
        check_value("thr7_at7", 32'(above), 32'd1);
        sync_clear = 2'b01;
        step();
        sync_clear = 2'b00;
        tick       = 1'b1;
        for (int i = 0; i < 3; i++) step();
        tick = 1'b0;
        check_value("at3_count", 32'(count), 32'd3);
        threshold = 3'd0;
        #1;
        check_value("thr0_at3", 32'(above), 32'd3);
        threshold = 3'd4;
        #1;
        check_value("thr4_at3", 32'(above), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sat_threshold_counter.md
SAT_THRESHOLD_COUNTER -- requirements
Module: sat_threshold_counter

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent counter channels (>=1).
REQ-002 Parameter WIDTH, default 3: bits per channel count (>=2).
REQ-003 Parameter LIMIT, default 7: terminal count per channel, 1..2**WIDTH-1.
REQ-004 Port clock  input  1: single clock; all state updates on its rising edge.
REQ-005 Port clear_n  input  1: reset, asynchronous, active-low.
REQ-006 Port tick  input  1: shared advance strobe (prescaler); counts advance only when high.
REQ-007 Port enable  input  CHANNELS: per-channel advance enable.
REQ-008 Port sync_clear  input  CHANNELS: per-channel synchronous clear to 0.
REQ-009 Port mode  input  CHANNELS: per-channel mode; 0 = saturate at LIMIT, 1 = wrap LIMIT->0.
REQ-010 Port threshold  input  WIDTH: shared compare value for above.
REQ-011 Port count  output  CHANNELS*WIDTH: packed channel counts, channel i at bits [i*WIDTH +: WIDTH].
REQ-012 Port above  output  CHANNELS: count_i >= threshold.
REQ-013 Port at_limit  output  CHANNELS: count_i == LIMIT.
REQ-014 Port done_pulse  output  CHANNELS: one-cycle terminal event flag.

Function
REQ-015 Per channel, advance condition SHALL be tick & enable[i] & ~sync_clear[i].
REQ-016 sync_clear[i] high SHALL load count_i = 0 at next edge, overriding any advance.
REQ-017 On advance with count_i < LIMIT, count_i SHALL increment by 1 at next edge.
REQ-018 On advance with count_i == LIMIT and mode[i]=0, count_i SHALL hold LIMIT.
REQ-019 On advance with count_i == LIMIT and mode[i]=1, count_i SHALL become 0.
REQ-020 Without advance or clear, count_i SHALL hold.
REQ-021 above and at_limit SHALL be combinational from the registered count and threshold (zero cycles after count update).
REQ-022 threshold = 0 SHALL give above = 1 for all channels; threshold > LIMIT SHALL give above = 0 always.
REQ-023 done_pulse[i] SHALL be registered, high for exactly the one cycle following an edge where count_i went LIMIT-1->LIMIT (either mode) or LIMIT->0 by wrap (mode 1).
REQ-024 Holding at LIMIT in saturate mode SHALL NOT re-assert done_pulse.
REQ-025 sync_clear from LIMIT SHALL NOT assert done_pulse.
REQ-026 mode[i] is sampled every cycle; a change takes effect on the next advance (e.g. saturated channel switched to mode 1 wraps on next advance).
REQ-027 Channels SHALL be fully independent; simultaneous events on different channels handled in the same cycle.
REQ-028 Arithmetic SHALL be WIDTH-bit unsigned; no intermediate overflow may alter counts.

Reset
REQ-029 clear_n low SHALL immediately force all counts to 0 and done_pulse to 0, regardless of clock.
REQ-030 During reset, above SHALL reflect count 0 vs threshold; at_limit = 0.
REQ-031 Reset deassertion mid-operation SHALL resume counting from 0 on the first advance edge after release.

Structure
REQ-032 Mode encodings (MODE_SATURATE=0, MODE_WRAP=1) SHALL live in shared package sat_counter_pkg.
REQ-033 One sub-module, sat_counter_channel (single channel: count, at_limit, above, done_pulse), SHALL be instantiated CHANNELS times by generate.
REQ-034 Elaboration SHALL fail for LIMIT outside 1..2**WIDTH-1 or CHANNELS < 1.

Verification (WIDTH=3, LIMIT=7, CHANNELS=2, threshold=4)
REQ-035 Reset, then tick=1, enable=01 for 10 cycles -> ch0 counts 1..7 then holds 7; above rises at count 4; done_pulse[0] one cycle after reaching 7; ch1 stays 0.
REQ-036 mode=01, enable=01, tick=1 for 9 cycles -> ch0 0..7 then 0,1; done_pulse[0] after reaching 7 and after wrap to 0.
REQ-037 tick toggled 1-0-1-0, enable=11 -> counts advance only on tick-high edges, both channels equal.
REQ-038 ch0 at 5, sync_clear[0]=1 with advance active -> count 0 next edge, no done_pulse; at 7, clear -> 0, no pulse.
REQ-039 clear_n pulsed low between clock edges at count 6 -> count 0 and done_pulse 0 immediately, counting resumes from 0.
REQ-040 threshold swept 0, 4, 7 at count 7 -> above 1, 1, 1; count 3 with threshold 0/4 -> above 1/0.
